// File: rtl/morse_encoder.sv
// Morse keyer fed by a UART byte stream; times marks and gaps in units of UNIT_CYCLES clocks.
// Define MORSE_FIFO_EN for a FIFO_DEPTH-entry character FIFO; otherwise one holding register.
module morse_encoder #(
  parameter int UNIT_CYCLES = 6_000_000,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = $clog2(7 * UNIT_CYCLES + 1)
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       morse_o,
  output logic       busy_o,
  output logic       full_o,
  output logic       overflow_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    MARK     = 3'd2,
    GAP      = 3'd3,
    CHAR_GAP = 3'd4,
    WORD_GAP = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] T1 = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T3 = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T4 = CNT_W'(4 * UNIT_CYCLES - 1);

  // Returns {length[2:0], pattern[4:0]} with the pattern left-aligned; length 0 = not encodable.
  function automatic logic [7:0] lookup(input logic [7:0] ch);
    logic [7:0] c;
    c = ((ch >= 8'h61) && (ch <= 8'h7A)) ? (ch - 8'h20) : ch;
    case (c)
      8'h41: lookup = {3'd2, 5'b01000};  8'h42: lookup = {3'd4, 5'b10000};
      8'h43: lookup = {3'd4, 5'b10100};  8'h44: lookup = {3'd3, 5'b10000};
      8'h45: lookup = {3'd1, 5'b00000};  8'h46: lookup = {3'd4, 5'b00100};
      8'h47: lookup = {3'd3, 5'b11000};  8'h48: lookup = {3'd4, 5'b00000};
      8'h49: lookup = {3'd2, 5'b00000};  8'h4A: lookup = {3'd4, 5'b01110};
      8'h4B: lookup = {3'd3, 5'b10100};  8'h4C: lookup = {3'd4, 5'b01000};
      8'h4D: lookup = {3'd2, 5'b11000};  8'h4E: lookup = {3'd2, 5'b10000};
      8'h4F: lookup = {3'd3, 5'b11100};  8'h50: lookup = {3'd4, 5'b01100};
      8'h51: lookup = {3'd4, 5'b11010};  8'h52: lookup = {3'd3, 5'b01000};
      8'h53: lookup = {3'd3, 5'b00000};  8'h54: lookup = {3'd1, 5'b10000};
      8'h55: lookup = {3'd3, 5'b00100};  8'h56: lookup = {3'd4, 5'b00010};
      8'h57: lookup = {3'd3, 5'b01100};  8'h58: lookup = {3'd4, 5'b10010};
      8'h59: lookup = {3'd4, 5'b10110};  8'h5A: lookup = {3'd4, 5'b11000};
      8'h30: lookup = {3'd5, 5'b11111};  8'h31: lookup = {3'd5, 5'b01111};
      8'h32: lookup = {3'd5, 5'b00111};  8'h33: lookup = {3'd5, 5'b00011};
      8'h34: lookup = {3'd5, 5'b00001};  8'h35: lookup = {3'd5, 5'b00000};
      8'h36: lookup = {3'd5, 5'b10000};  8'h37: lookup = {3'd5, 5'b11000};
      8'h38: lookup = {3'd5, 5'b11100};  8'h39: lookup = {3'd5, 5'b11110};
      default: lookup = 8'h00;
    endcase
  endfunction

  state_t           state_r, state_next;
  logic [CNT_W-1:0] timer_r, timer_next;
  logic [4:0]       pat_r, pat_next;
  logic [2:0]       len_r, len_next;
  logic             morse_r, overflow_r;
  logic             push_s, pop_s, empty_s, full_s;
  logic [7:0]       head_s, code_s;

  // full is judged on the registered occupancy, so a same-cycle pop never admits a write
  assign push_s = valid_i & ~full_s;
  assign pop_s  = (state_r == LOAD);

`ifdef MORSE_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]  mem_r [FIFO_DEPTH];
  logic [AW:0] wptr_r, rptr_r, count_s;

  assign count_s = wptr_r - rptr_r;
  assign full_s  = (count_s == DEPTH_V);
  assign empty_s = (wptr_r == rptr_r);
  assign head_s  = mem_r[rptr_r[AW-1:0]];

  // FIFO pointers; the extra MSB distinguishes full from empty
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push_s) wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
      if (pop_s)  rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (push_s) mem_r[wptr_r[AW-1:0]] <= data_i;
  end
`else
  logic [7:0] hold_r;
  logic       hold_vld_r;

  assign full_s  = hold_vld_r;
  assign empty_s = ~hold_vld_r;
  assign head_s  = hold_r;

  // Single holding register; push and pop are exclusive since LOAD implies it is occupied
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_r     <= 8'h00;
      hold_vld_r <= 1'b0;
    end else if (push_s) begin
      hold_r     <= data_i;
      hold_vld_r <= 1'b1;
    end else if (pop_s) begin
      hold_vld_r <= 1'b0;
    end
  end
`endif

  assign code_s = lookup(head_s);

  // State, timer and element registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      timer_r    <= '0;
      pat_r      <= 5'd0;
      len_r      <= 3'd0;
      morse_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_next;
      timer_r    <= timer_next;
      pat_r      <= pat_next;
      len_r      <= len_next;
      morse_r    <= (state_next == MARK);
      overflow_r <= overflow_r | (valid_i & full_s);
    end
  end

  // Next-state logic; IDLE also reacts to a write arriving this cycle to save a clock of latency
  always_comb begin
    state_next = state_r;
    timer_next = timer_r;
    pat_next   = pat_r;
    len_next   = len_r;
    case (state_r)
      IDLE: begin
        timer_next = '0;
        if (!empty_s || push_s) state_next = LOAD;
        else                    state_next = IDLE;
      end
      LOAD: begin
        pat_next = code_s[4:0];
        len_next = code_s[7:5];
        if (code_s[7:5] != 3'd0) begin
          state_next = MARK;
          timer_next = code_s[4] ? T3 : T1;
        end else if (head_s == 8'h20) begin
          state_next = WORD_GAP;
          timer_next = T4;
        end else begin
          state_next = IDLE;
        end
      end
      MARK: begin
        if (timer_r != '0) begin
          timer_next = timer_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (len_r > 3'd1) begin
          state_next = GAP;
          timer_next = T1;
          pat_next   = {pat_r[3:0], 1'b0};
          len_next   = len_r - 3'd1;
        end else begin
          state_next = CHAR_GAP;
          timer_next = T3;
        end
      end
      GAP: begin
        if (timer_r != '0) begin
          timer_next = timer_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_next = MARK;
          timer_next = pat_r[4] ? T3 : T1;
        end
      end
      CHAR_GAP, WORD_GAP: begin
        if (timer_r != '0) timer_next = timer_r - {{(CNT_W-1){1'b0}}, 1'b1};
        else               state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  assign morse_o    = morse_r;
  assign busy_o     = (state_r != IDLE) | ~empty_s;
  assign full_o     = full_s;
  assign overflow_o = overflow_r;

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with UNIT_CYCLES=4, FIFO_DEPTH=4.
module tb_morse_encoder;
  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic       valid;
  logic       morse, busy, full, overflow;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] tx_q[$];
  bit         mo_q[$];
  int         runs_q[$];
  bit         timeout;

  morse_encoder #(.UNIT_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .reset_i(reset), .data_i(data), .valid_i(valid),
    .morse_o(morse), .busy_o(busy), .full_o(full), .overflow_o(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes tx_q whenever full is low and records morse from the cycle after the first write until idle.
  task automatic run_chars(input int max_cycles);
    bit started;
    bit done;
    started = 1'b0;
    done    = 1'b0;
    mo_q.delete();
    for (int c = 0; c < max_cycles && !done; c++) begin
      if (started && !busy && tx_q.size() == 0) begin
        done = 1'b1;
      end else begin
        if (started) mo_q.push_back(morse);
        if (tx_q.size() > 0 && !full) begin
          valid   = 1'b1;
          data    = tx_q.pop_front();
          started = 1'b1;
        end else begin
          valid = 1'b0;
        end
        tick();
      end
    end
    valid   = 1'b0;
    timeout = !done;
  endtask

  // Run-length encodes mo_q; the first run is always the low LOAD cycle.
  task automatic build_runs();
    int last;
    runs_q.delete();
    foreach (mo_q[i]) begin
      if (i == 0) begin
        runs_q.push_back(1);
      end else if (mo_q[i] != mo_q[i-1]) begin
        runs_q.push_back(1);
      end else begin
        last = runs_q.pop_back();
        runs_q.push_back(last + 1);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid = 1'b0;
    tick();
    tick();
    n_cmp++; if (morse !== 1'b0)    begin n_bad++; $display("FAIL reset_morse got %b want 0", morse); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (full !== 1'b0)     begin n_bad++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_e(input string tag);
    int exp_r[3] = '{1, 4, 12};
    tx_q = '{8'h45};
    run_chars(200);
    build_runs();
    n_cmp++; if (timeout) begin n_bad++; $display("FAIL %s_timeout got busy=%b want 0", tag, busy); end
    n_cmp++; if (runs_q.size() != 3) begin n_bad++; $display("FAIL %s_nruns got %0d want 3", tag, runs_q.size()); end
    for (int i = 0; i < 3 && i < runs_q.size(); i++) begin
      n_cmp++;
      if (runs_q[i] != exp_r[i]) begin n_bad++; $display("FAIL %s_run%0d got %0d want %0d", tag, i, runs_q[i], exp_r[i]); end
    end
  endtask

  task automatic test_lower();
    int exp_r[5] = '{1, 4, 4, 12, 12};
    logic [7:0] chars[2] = '{8'h61, 8'h41};
    for (int k = 0; k < 2; k++) begin
      tx_q = '{chars[k]};
      run_chars(200);
      build_runs();
      n_cmp++; if (timeout) begin n_bad++; $display("FAIL a_timeout char=%h got busy=%b want 0", chars[k], busy); end
      n_cmp++; if (runs_q.size() != 5) begin n_bad++; $display("FAIL a_nruns char=%h got %0d want 5", chars[k], runs_q.size()); end
      for (int i = 0; i < 5 && i < runs_q.size(); i++) begin
        n_cmp++;
        if (runs_q[i] != exp_r[i]) begin n_bad++; $display("FAIL a_run%0d char=%h got %0d want %0d", i, chars[k], runs_q[i], exp_r[i]); end
      end
    end
  endtask

  task automatic test_digit();
    int exp_r[11] = '{1, 12, 4, 12, 4, 12, 4, 12, 4, 12, 12};
    int sum;
    tx_q = '{8'h30};
    run_chars(300);
    build_runs();
    n_cmp++; if (timeout) begin n_bad++; $display("FAIL zero_timeout got busy=%b want 0", busy); end
    n_cmp++; if (runs_q.size() != 11) begin n_bad++; $display("FAIL zero_nruns got %0d want 11", runs_q.size()); end
    sum = 0;
    for (int i = 0; i < 11 && i < runs_q.size(); i++) begin
      if (i >= 1 && i <= 9) sum += runs_q[i];
      n_cmp++;
      if (runs_q[i] != exp_r[i]) begin n_bad++; $display("FAIL zero_run%0d got %0d want %0d", i, runs_q[i], exp_r[i]); end
    end
    n_cmp++; if (sum != 76) begin n_bad++; $display("FAIL zero_markgap_total got %0d want 76", sum); end
  endtask

  task automatic test_word();
    int exp_r[5] = '{1, 4, 32, 4, 12};
    tx_q = '{8'h45, 8'h20, 8'h45};
    run_chars(400);
    build_runs();
    n_cmp++; if (timeout) begin n_bad++; $display("FAIL word_timeout got busy=%b want 0", busy); end
    n_cmp++; if (runs_q.size() != 5) begin n_bad++; $display("FAIL word_nruns got %0d want 5", runs_q.size()); end
    for (int i = 0; i < 5 && i < runs_q.size(); i++) begin
      n_cmp++;
      if (runs_q[i] != exp_r[i]) begin n_bad++; $display("FAIL word_run%0d got %0d want %0d", i, runs_q[i], exp_r[i]); end
    end
  endtask

  task automatic test_unsupported();
    int highs;
    tx_q = '{8'h23};
    run_chars(50);
    highs = 0;
    foreach (mo_q[i]) if (mo_q[i]) highs++;
    n_cmp++; if (timeout) begin n_bad++; $display("FAIL hash_timeout got busy=%b want 0", busy); end
    n_cmp++; if (mo_q.size() != 1) begin n_bad++; $display("FAIL hash_busy_len got %0d want 1", mo_q.size()); end
    n_cmp++; if (highs != 0) begin n_bad++; $display("FAIL hash_marks got %0d want 0", highs); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL hash_overflow got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
`ifdef MORSE_FIFO_EN
    int n_wr = 6;
    int exp_dashes = 5;
`else
    int n_wr = 2;
    int exp_dashes = 1;
`endif
    int dashes;
    bit prev;
    bit done;
    dashes = 0;
    prev   = 1'b0;
    done   = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      if (morse && !prev) dashes++;
      prev = morse;
      if (c == n_wr - 1) begin
        n_cmp++; if (full !== 1'b1)     begin n_bad++; $display("FAIL ovf_full_at_last_write got %b want 1", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early got %b want 0", overflow); end
      end
      if (c == n_wr) begin
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", overflow); end
      end
      if (c > n_wr && !busy) begin
        done = 1'b1;
      end else begin
        valid = (c < n_wr);
        data  = 8'h54;
        tick();
      end
    end
    valid = 1'b0;
    n_cmp++; if (!done) begin n_bad++; $display("FAIL ovf_timeout got busy=%b want 0", busy); end
    n_cmp++; if (dashes != exp_dashes) begin n_bad++; $display("FAIL ovf_dashes got %0d want %0d", dashes, exp_dashes); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    valid = 1'b1;
    data  = 8'h54;
    tick();
    valid = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++; if (morse !== 1'b1) begin n_bad++; $display("FAIL mid_in_dash got %b want 1", morse); end
    reset = 1'b1;
    tick();
    n_cmp++; if (morse !== 1'b0)    begin n_bad++; $display("FAIL mid_morse got %b want 0", morse); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL mid_busy got %b want 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL mid_overflow got %b want 0", overflow); end
    n_cmp++; if (full !== 1'b0)     begin n_bad++; $display("FAIL mid_full got %b want 0", full); end
    reset = 1'b0;
    tick();
    test_e("post_reset_e");
  endtask

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    test_reset();
    test_e("e");
    test_lower();
    test_digit();
    test_word();
    test_unsupported();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
